// File: rtl/demod_sym_packer_pkg.sv
// Shared constants for the OFDM data-symbol path: symbol geometry, pilot
// positions (also used by the demapper pilot logic), modulation encodings
// and the packer FSM states.
package demod_sym_packer_pkg;

    // Subcarrier entries per OFDM symbol, data plus pilots
    localparam int SYM_LEN = 52;
    // Zero-based pilot entry positions within a symbol
    localparam int PIL0 = 6;
    localparam int PIL1 = 20;
    localparam int PIL2 = 31;
    localparam int PIL3 = 45;
    // log2 of the output byte FIFO depth
    localparam int FIFO_AW = 3;
    // Width of the per-symbol entry index
    localparam int IDX_W = 6;

    // MODE input encodings
    localparam logic MODE_QAM16 = 1'b0;
    localparam logic MODE_QPSK  = 1'b1;

    // Packer control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // True when the entry index addresses a pilot subcarrier
    function automatic logic is_pilot(input logic [IDX_W-1:0] idx);
        return (idx == PIL0[IDX_W-1:0]) || (idx == PIL1[IDX_W-1:0]) ||
               (idx == PIL2[IDX_W-1:0]) || (idx == PIL3[IDX_W-1:0]);
    endfunction

endpackage

// File: rtl/demod_sym_packer_sym_byte_fifo.sv
// First-word-fall-through byte FIFO carrying {SOS, byte}.
// A push while full is taken only when a pop frees the slot in the same cycle.
module sym_byte_fifo #(
    parameter int AW = 3,
    parameter int W  = 9
) (
    input  logic         CLK_I,
    input  logic         RST_I,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH[AW:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because empty masks the head
    always_ff @(posedge CLK_I) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demod_sym_packer.sv
// Demapped-symbol packer: accepts one subcarrier bit group per entry,
// discards pilot positions, packs data bits LSB-first into bytes and hands
// them downstream through a small FWFT FIFO with STB/ACK back-pressure.
//
// Handshake: upstream entry is consumed in every cycle with ACK_O=1
// (combinational from CYC_I/STB_I/WE_I, FIFO space and state); downstream
// byte is consumed in every cycle with STB_O=1 and ACK_I=1.
//
// A new burst may be accepted in the same cycle CYC_I is first seen in
// IDLE or DRAIN; the "cur_*" signals give that cycle its fresh context
// (MODE taken live, index 0, empty partial byte, symbol start pending).
module demod_sym_packer
    import demod_sym_packer_pkg::*;
(
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [3:0] DAT_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic       WE_I,
    output logic       ACK_O,
    input  logic       MODE,
    output logic [7:0] DAT_O,
    output logic       SOS_O,
    output logic       CYC_O,
    output logic       STB_O,
    output logic       WE_O,
    input  logic       ACK_I,
    output logic [7:0] SYM_CNT
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_LEN - 1);

    state_t           state;
    logic             mode_q;
    logic [IDX_W-1:0] idx;
    logic [7:0]       part;
    logic [1:0]       slot;
    logic             sos_pend;
    logic [7:0]       sym_cnt_q;
    logic             cyc_o_q;

    logic             burst_start;
    logic             cur_mode;
    logic [IDX_W-1:0] cur_idx;
    logic [7:0]       cur_part;
    logic [1:0]       cur_slot;
    logic             cur_sos;
    logic             accept;
    logic             data_acc;
    logic             byte_done;
    logic             wrap;
    logic             flush_push;
    logic [7:0]       next_part;

    logic             push;
    logic [8:0]       push_data;
    logic             pop;
    logic [8:0]       head;
    logic             fifo_full;
    logic             fifo_empty;

    assign burst_start = CYC_I & ((state == IDLE) | (state == DRAIN));
    assign cur_mode    = burst_start ? MODE : mode_q;
    assign cur_idx     = burst_start ? '0 : idx;
    assign cur_part    = burst_start ? '0 : part;
    assign cur_slot    = burst_start ? '0 : slot;
    assign cur_sos     = burst_start ? 1'b1 : sos_pend;

    assign accept     = RST_I & CYC_I & STB_I & WE_I & ~fifo_full & (state != FLUSH);
    assign data_acc   = accept & ~is_pilot(cur_idx);
    assign wrap       = accept & (cur_idx == LAST_IDX);
    assign byte_done  = data_acc & ((cur_mode == MODE_QAM16) ? (cur_slot == 2'd1)
                                                             : (cur_slot == 2'd3));
    assign flush_push = (state == FLUSH) & ~fifo_full;

    // Insert the incoming bit group into the partial byte at the current slot
    always_comb begin
        next_part = cur_part;
        if (cur_mode == MODE_QAM16) begin
            if (cur_slot[0] == 1'b0) begin
                next_part = {4'h0, DAT_I};
            end else begin
                next_part = {DAT_I, cur_part[3:0]};
            end
        end else begin
            case (cur_slot)
                2'd0:    next_part = {6'b0, DAT_I[1:0]};
                2'd1:    next_part[3:2] = DAT_I[1:0];
                2'd2:    next_part[5:4] = DAT_I[1:0];
                default: next_part[7:6] = DAT_I[1:0];
            endcase
        end
    end

    assign push      = byte_done | flush_push;
    assign push_data = flush_push ? {sos_pend, part} : {cur_sos, next_part};
    assign pop       = ~fifo_empty & ACK_I;

    sym_byte_fifo #(
        .AW (FIFO_AW),
        .W  (9)
    ) u_fifo (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Entry index, packing state, symbol-start flag and symbol counter
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            mode_q    <= MODE_QAM16;
            idx       <= '0;
            part      <= '0;
            slot      <= '0;
            sos_pend  <= 1'b0;
            sym_cnt_q <= '0;
        end else begin
            if (burst_start) begin
                mode_q <= MODE;
            end

            if (accept) begin
                idx <= (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
            end else begin
                idx <= cur_idx;
            end

            if (byte_done || flush_push) begin
                part <= '0;
                slot <= '0;
            end else if (data_acc) begin
                part <= next_part;
                slot <= cur_slot + 1'b1;
            end else begin
                part <= cur_part;
                slot <= cur_slot;
            end

            // The byte that closes a symbol keeps the old flag; the next one starts fresh
            if (wrap) begin
                sos_pend <= 1'b1;
            end else if (push) begin
                sos_pend <= 1'b0;
            end else begin
                sos_pend <= cur_sos;
            end

            if (burst_start) begin
                sym_cnt_q <= '0;
            end else if (wrap) begin
                sym_cnt_q <= sym_cnt_q + 1'b1;
            end
        end
    end

    // Burst control FSM with registered downstream cycle flag
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state   <= IDLE;
            cyc_o_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CYC_I) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!CYC_I) begin
                        state <= (slot == '0) ? DRAIN : FLUSH;
                    end
                end
                FLUSH: begin
                    if (!fifo_full) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A new burst overrides the return to IDLE, keeping CYC_O high
                    if (CYC_I) begin
                        state <= RUN;
                    end else if (fifo_empty) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if ((state == DRAIN) && !CYC_I && fifo_empty) begin
                cyc_o_q <= 1'b0;
            end else if (push) begin
                cyc_o_q <= 1'b1;
            end
        end
    end

    assign ACK_O   = accept;
    assign STB_O   = ~fifo_empty;
    assign WE_O    = ~fifo_empty;
    assign DAT_O   = fifo_empty ? 8'h00 : head[7:0];
    assign SOS_O   = ~fifo_empty & head[8];
    assign CYC_O   = cyc_o_q;
    assign SYM_CNT = sym_cnt_q;

endmodule

// File: tb/tb_demod_sym_packer.sv
// Directed bench for demod_sym_packer: one linear sequence of bursts with
// hand-computed byte streams, checked by immediate assertions.
module tb_demod_sym_packer;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic [3:0] DAT_I = 4'h0;
    logic       CYC_I = 1'b0;
    logic       STB_I = 1'b0;
    logic       WE_I  = 1'b0;
    logic       MODE  = 1'b0;
    logic       ACK_I = 1'b1;
    logic       ACK_O;
    logic [7:0] DAT_O;
    logic       SOS_O;
    logic       CYC_O;
    logic       STB_O;
    logic       WE_O;
    logic [7:0] SYM_CNT;

    int tests = 0;
    int fails = 0;
    int stall_k = -1;
    int cyc_drops = 0;
    bit cyc_watch = 1'b0;

    logic [8:0] got_q[$];

    // 16-QAM symbol, DAT_I = idx%16, pilots 6/20/31/45 removed, two nibbles per byte
    logic [7:0] qam_tbl [24] = '{
        8'h10, 8'h32, 8'h54, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F,
        8'h21, 8'h53, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'h0E, 8'h21,
        8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hFE, 8'h10, 8'h32
    };

    demod_sym_packer dut (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .DAT_I   (DAT_I),
        .CYC_I   (CYC_I),
        .STB_I   (STB_I),
        .WE_I    (WE_I),
        .ACK_O   (ACK_O),
        .MODE    (MODE),
        .DAT_O   (DAT_O),
        .SOS_O   (SOS_O),
        .CYC_O   (CYC_O),
        .STB_O   (STB_O),
        .WE_O    (WE_O),
        .ACK_I   (ACK_I),
        .SYM_CNT (SYM_CNT)
    );

    // Clock
    always #5 CLK_I = ~CLK_I;

    // Output collector: a byte is taken when STB_O and ACK_I meet before the edge
    always @(negedge CLK_I) begin
        if (RST_I && STB_O && ACK_I) begin
            got_q.push_back({SOS_O, DAT_O});
        end
        if (cyc_watch && got_q.size() > 0 && !CYC_O) begin
            cyc_drops++;
        end
    end

    // Absolute time limit
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end, time limit expired");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive n entries; pat 0 gives DAT_I = idx%16, pat 1 gives 4'b0001
    task automatic send(input logic m, input int n, input int pat, input bit flip);
        int   guard;
        logic acc;
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b1;
        MODE  = m;
        stall_k = -1;
        for (int k = 0; k < n; k++) begin
            DAT_I = (pat == 0) ? 4'(k % 16) : 4'b0001;
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                @(negedge CLK_I);
                acc = ACK_O;
                if (!acc && stall_k < 0) stall_k = k;
                @(posedge CLK_I);
                #1;
                guard++;
            end
            if (!acc) begin
                tests++;
                fails++;
                $error("FAIL send_timeout: entry %0d not accepted, required acceptance within 200 cycles", k);
                STB_I = 1'b0;
                WE_I  = 1'b0;
                return;
            end
            if (flip && k == 0) MODE = ~m;
        end
        STB_I = 1'b0;
        WE_I  = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int g;
        g = 0;
        while (got_q.size() < n && g < 400) begin
            @(posedge CLK_I);
            #1;
            g++;
        end
        chk("byte_count", got_q.size(), n);
    endtask

    task automatic check_qam(input int off);
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("qam_byte%0d", i), got_q[off+i][7:0], qam_tbl[i]);
            chk($sformatf("qam_sos%0d", i), got_q[off+i][8], (i == 0));
        end
    endtask

    task automatic check_qpsk(input int off);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("qpsk_byte%0d", i), got_q[off+i][7:0], 8'h55);
            chk($sformatf("qpsk_sos%0d", i), got_q[off+i][8], (i == 0));
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK_I);
        #1;
    endtask

    initial begin
        // Reset state
        idle_cycles(2);
        chk("rst_stb", STB_O, 0);
        chk("rst_we", WE_O, 0);
        chk("rst_cyc", CYC_O, 0);
        chk("rst_ack", ACK_O, 0);
        chk("rst_dat", DAT_O, 0);
        chk("rst_sos", SOS_O, 0);
        chk("rst_symcnt", SYM_CNT, 0);
        RST_I = 1'b1;
        idle_cycles(2);

        // 1: one 16-QAM symbol, sink always ready
        got_q.delete();
        send(1'b0, 52, 0, 1'b0);
        chk("t1_symcnt", SYM_CNT, 1);
        CYC_I = 1'b0;
        wait_bytes(24);
        check_qam(0);
        idle_cycles(4);
        chk("t1_cyc_idle", CYC_O, 0);

        // 2: sink stalled for the first 30 cycles
        got_q.delete();
        ACK_I = 1'b0;
        fork
            send(1'b0, 52, 0, 1'b0);
            begin
                repeat (30) @(posedge CLK_I);
                #1;
                ACK_I = 1'b1;
            end
        join
        chk("t2_stall_entry", stall_k, 17);
        CYC_I = 1'b0;
        wait_bytes(24);
        check_qam(0);
        idle_cycles(4);

        // 3: QPSK symbol of 01 dibits; MODE flipped after the first entry is ignored
        got_q.delete();
        send(1'b1, 52, 1, 1'b1);
        chk("t3_symcnt", SYM_CNT, 1);
        CYC_I = 1'b0;
        wait_bytes(12);
        check_qpsk(0);
        idle_cycles(4);

        // 4: truncated 16-QAM burst, idx 0..9 gives nine data nibbles
        got_q.delete();
        send(1'b0, 10, 0, 1'b0);
        CYC_I = 1'b0;
        wait_bytes(5);
        chk("t4_cyc_at_last_pop", CYC_O, 1);
        chk("t4_b0", got_q[0], 9'h110);
        chk("t4_b1", got_q[1], 9'h032);
        chk("t4_b2", got_q[2], 9'h054);
        chk("t4_b3", got_q[3], 9'h087);
        chk("t4_flush", got_q[4], 9'h009);
        idle_cycles(3);
        chk("t4_cyc_low", CYC_O, 0);
        chk("t4_stb_low", STB_O, 0);

        // 5: reset while entry 20 is being offered
        got_q.delete();
        send(1'b0, 20, 0, 1'b0);
        STB_I = 1'b1;
        WE_I  = 1'b1;
        DAT_I = 4'h4;
        RST_I = 1'b0;
        #1;
        chk("t5_stb", STB_O, 0);
        chk("t5_cyc", CYC_O, 0);
        chk("t5_ack", ACK_O, 0);
        chk("t5_symcnt", SYM_CNT, 0);
        idle_cycles(1);
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        RST_I = 1'b1;
        idle_cycles(2);
        got_q.delete();
        send(1'b0, 52, 0, 1'b0);
        CYC_I = 1'b0;
        wait_bytes(24);
        check_qam(0);
        idle_cycles(4);

        // 6: QPSK burst then 16-QAM burst, one idle cycle between
        got_q.delete();
        cyc_drops = 0;
        cyc_watch = 1'b1;
        send(1'b1, 52, 1, 1'b0);
        CYC_I = 1'b0;
        idle_cycles(1);
        send(1'b0, 52, 0, 1'b0);
        chk("t6_symcnt", SYM_CNT, 1);
        CYC_I = 1'b0;
        wait_bytes(36);
        cyc_watch = 1'b0;
        check_qpsk(0);
        check_qam(12);
        chk("t6_cyc_drops", cyc_drops, 0);
        idle_cycles(4);
        chk("t6_cyc_idle", CYC_O, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
